// File: rtl/ft232h_pkg.sv
// Shared types for the FT232H synchronous FIFO controller: FSM states, grant
// direction and ACBUS pin indices.
package ft232h_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_RD,
    RX_END,
    TX_WR
  } state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

  localparam int ACBUS_RXF    = 0;
  localparam int ACBUS_TXE    = 1;
  localparam int ACBUS_RD     = 2;
  localparam int ACBUS_WR     = 3;
  localparam int ACBUS_SIWU   = 4;
  localparam int ACBUS_CLKOUT = 5;
  localparam int ACBUS_OE     = 6;

endpackage

// File: rtl/ft232h_sync_fifo_ctrl_fifo.sv
// Small synchronous FIFO used as the RX skid buffer; exposes occupancy so the
// read-strobe decision can look one byte ahead.
module ft232h_sync_fifo_ctrl_fifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // a full buffer may still accept a byte when one leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (ADDR_WIDTH+1)'(w_do_push) - (ADDR_WIDTH+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/ft232h_sync_fifo_ctrl.sv
// FT245 synchronous-FIFO master for the FT232H: arbitrates the half-duplex
// ADBUS between RX and TX bursts and sequences OE#/RD#/WR# with turnaround.
module ft232h_sync_fifo_ctrl
  import ft232h_pkg::*;
#(
  parameter int MAX_BURST     = 64,
  parameter int RX_SKID_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxf_n,
  input  logic       txe_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       siwu_n,
  output logic       oe_n,
  input  logic [7:0] adbus_i,
  output logic [7:0] adbus_o,
  output logic       adbus_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int SKID_AW = $clog2(RX_SKID_DEPTH);
  localparam int CW      = SKID_AW + 1;
  localparam int BW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] SKID_FULL = {1'b1, {SKID_AW{1'b0}}};
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_t        r_state, w_state_nxt;
  grant_t        r_last_grant, w_last_grant_nxt;
  logic          r_oe_n, w_oe_n_nxt;
  logic          r_rd_n, w_rd_n_nxt;
  logic          r_wr_n, w_wr_n_nxt;
  logic          r_adbus_oe, w_adbus_oe_nxt;
  logic [7:0]    r_adbus_o, w_adbus_o_nxt;
  logic [BW-1:0] r_burst, w_burst_nxt, w_burst_inc;
  logic          r_hold_vld, w_hold_vld_nxt;
  logic [7:0]    r_hold_data, w_hold_data_nxt;

  logic          w_rx_xfer, w_tx_xfer, w_pop, w_tx_accept;
  logic          w_skid_empty, w_skid_full;
  logic [CW-1:0] w_skid_count, w_occ_after;
  logic          w_rx_req, w_tx_req, w_rx_go;

  ft232h_sync_fifo_ctrl_fifo #(
    .ADDR_WIDTH (SKID_AW),
    .DATA_WIDTH (8)
  ) u_rx_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_xfer),
    .i_data  (adbus_i),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_empty (w_skid_empty),
    .o_full  (w_skid_full),
    .o_count (w_skid_count)
  );

  assign rx_valid    = !w_skid_empty;
  assign w_pop       = rx_valid && rx_ready;
  assign w_rx_xfer   = !r_rd_n && !rxf_n;
  assign w_tx_xfer   = !r_wr_n && !txe_n;
  assign tx_ready    = !reset && (!r_hold_vld || w_tx_xfer);
  assign w_tx_accept = tx_valid && tx_ready;

  assign w_hold_vld_nxt  = w_tx_accept ? 1'b1 : (w_tx_xfer ? 1'b0 : r_hold_vld);
  assign w_hold_data_nxt = w_tx_accept ? tx_data : r_hold_data;

  assign w_burst_inc = ((w_rx_xfer || w_tx_xfer) && (r_burst != BURST_MAX)) ?
                       r_burst + 1'b1 : r_burst;
  assign w_occ_after = w_skid_count + CW'(w_rx_xfer) - CW'(w_pop);

  assign w_rx_req = !rxf_n && !w_skid_full;
  assign w_tx_req = r_hold_vld && !txe_n;
  // rd_n is registered: one more byte may land after this decision, so it must fit
  assign w_rx_go  = !rxf_n && (w_burst_inc < BURST_MAX) && (w_occ_after < SKID_FULL);

  assign rd_n     = r_rd_n;
  assign wr_n     = r_wr_n;
  assign oe_n     = r_oe_n;
  assign siwu_n   = 1'b1;
  assign adbus_o  = r_adbus_o;
  assign adbus_oe = r_adbus_oe;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_oe_n_nxt       = 1'b1;
    w_rd_n_nxt       = 1'b1;
    w_wr_n_nxt       = 1'b1;
    w_adbus_oe_nxt   = 1'b0;
    w_adbus_o_nxt    = r_adbus_o;
    w_burst_nxt      = w_burst_inc;
    case (r_state)
      IDLE: begin
        if (w_rx_req && (!w_tx_req || r_last_grant == GRANT_TX)) begin
          w_state_nxt = RX_OE;
          w_oe_n_nxt  = 1'b0;
          w_burst_nxt = '0;
        end else if (w_tx_req) begin
          w_state_nxt    = TX_WR;
          w_wr_n_nxt     = 1'b0;
          w_adbus_oe_nxt = 1'b1;
          w_adbus_o_nxt  = r_hold_data;
          w_burst_nxt    = '0;
        end
      end
      RX_OE: begin
        w_state_nxt = RX_RD;
        w_oe_n_nxt  = 1'b0;
        w_rd_n_nxt  = !w_rx_go;
      end
      RX_RD: begin
        if (w_rx_go) begin
          w_oe_n_nxt = 1'b0;
          w_rd_n_nxt = 1'b0;
        end else begin
          w_state_nxt = RX_END;
        end
      end
      RX_END: begin
        w_state_nxt      = IDLE;
        w_last_grant_nxt = GRANT_RX;
      end
      TX_WR: begin
        if (w_hold_vld_nxt && !txe_n && (w_burst_inc < BURST_MAX)) begin
          w_wr_n_nxt     = 1'b0;
          w_adbus_oe_nxt = 1'b1;
          w_adbus_o_nxt  = w_hold_data_nxt;
        end else begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = GRANT_TX;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_TX;
      r_oe_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_adbus_oe   <= 1'b0;
      r_adbus_o    <= 8'h00;
      r_burst      <= '0;
      r_hold_vld   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_oe_n       <= w_oe_n_nxt;
      r_rd_n       <= w_rd_n_nxt;
      r_wr_n       <= w_wr_n_nxt;
      r_adbus_oe   <= w_adbus_oe_nxt;
      r_adbus_o    <= w_adbus_o_nxt;
      r_burst      <= w_burst_nxt;
      r_hold_vld   <= w_hold_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_hold_data <= w_hold_data_nxt;
  end

endmodule

// File: tb/tb_ft232h_sync_fifo_ctrl.sv
// Bench for ft232h_sync_fifo_ctrl: FT232H sync-FIFO host model on a muxed ADBUS,
// table-driven transfer vectors plus hand-written stall, arbitration and reset sequences.
module tb_ft232h_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxf_n, txe_n, rd_n, wr_n, siwu_n, oe_n;
  logic [7:0] adbus_pin, adbus_o;
  logic       adbus_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;

  ft232h_sync_fifo_ctrl #(.MAX_BURST(4), .RX_SKID_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .wr_n(wr_n),
    .siwu_n(siwu_n), .oe_n(oe_n), .adbus_i(adbus_pin), .adbus_o(adbus_o), .adbus_oe(adbus_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial forever #5 clk = ~clk;

  // host (FT232H) side
  logic [7:0] h_rx_mem [0:255];
  int         h_rx_wr = 0, h_rx_rd = 0;
  logic       h_flush = 1'b0;
  logic       txe_force = 1'b0;
  logic [7:0] h_tx_log [0:255];
  int         h_tx_n = 0;
  // stream side
  logic [7:0] p_tx_mem [0:255];
  int         p_tx_cnt = 0, p_tx_idx = 0;
  logic [7:0] c_rx_log [0:255];
  int         c_rx_n = 0;
  // monitors
  int         cyc = 0, rd_lo_cnt = 0, wr_lo_cnt = 0, bus_viol = 0;
  int         oe_fall_cyc = 0, oe_rd_bad = 0, oe_rd_seen = 0;
  logic       await_rd = 1'b0, oe_prev = 1'b1, wr_prev = 1'b1;
  logic       burst_dir [0:255];
  int         burst_len [0:255];
  int         n_bursts = 0;

  int n_total = 0, n_pass = 0;

  always_comb rxf_n = (h_rx_rd >= h_rx_wr);
  always_comb txe_n = txe_force;
  always_comb begin
    if (adbus_oe)   adbus_pin = adbus_o;
    else if (!oe_n) adbus_pin = h_rx_mem[h_rx_rd];
    else            adbus_pin = 8'h00;
  end
  always_comb tx_valid = (p_tx_idx < p_tx_cnt);
  always_comb tx_data  = p_tx_mem[p_tx_idx];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (h_flush) h_rx_rd <= h_rx_wr;
    else if (!rd_n && !rxf_n) h_rx_rd <= h_rx_rd + 1;
    if (!wr_n && !txe_n) begin
      h_tx_log[h_tx_n] <= adbus_pin;
      h_tx_n <= h_tx_n + 1;
    end
    if (rx_valid && rx_ready) begin
      c_rx_log[c_rx_n] <= rx_data;
      c_rx_n <= c_rx_n + 1;
    end
    if (tx_valid && tx_ready) p_tx_idx <= p_tx_idx + 1;
    if (!rd_n) rd_lo_cnt <= rd_lo_cnt + 1;
    if (!wr_n) wr_lo_cnt <= wr_lo_cnt + 1;
    if (adbus_oe && (!oe_n || !oe_prev)) bus_viol <= bus_viol + 1;
    oe_prev <= oe_n;
    wr_prev <= wr_n;
    if (oe_prev && !oe_n) begin
      burst_dir[n_bursts] <= 1'b0;
      burst_len[n_bursts] <= 0;
      n_bursts <= n_bursts + 1;
      oe_fall_cyc <= cyc;
      await_rd <= 1'b1;
    end else if (wr_prev && !wr_n) begin
      burst_dir[n_bursts] <= 1'b1;
      burst_len[n_bursts] <= txe_n ? 0 : 1;
      n_bursts <= n_bursts + 1;
    end else if (n_bursts > 0 && ((!rd_n && !rxf_n) || (!wr_n && !txe_n))) begin
      burst_len[n_bursts-1] <= burst_len[n_bursts-1] + 1;
    end
    if (await_rd && !rd_n) begin
      await_rd <= 1'b0;
      oe_rd_seen <= oe_rd_seen + 1;
      if (cyc - oe_fall_cyc != 1) oe_rd_bad <= oe_rd_bad + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic queue_rx(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) h_rx_mem[h_rx_wr + i] = base + 8'(i);
    h_rx_wr = h_rx_wr + n;
  endtask

  task automatic queue_tx(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) p_tx_mem[p_tx_cnt + i] = base + 8'(i);
    p_tx_cnt = p_tx_cnt + n;
  endtask

  task automatic wait_done(input int rx_target, input int tx_target, input string name);
    int budget = 1000;
    while ((c_rx_n < rx_target || h_tx_n < tx_target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, " completes"}, (budget > 0) ? 1 : 0, 1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input int start, input int n, input logic [7:0] base);
    logic [7:0] eb;
    check({name, " rx count"}, c_rx_n - start, n);
    for (int i = 0; i < n; i++) begin
      eb = base + 8'(i);
      check($sformatf("%s rx[%0d]", name, i), int'(c_rx_log[start + i]), int'(eb));
    end
  endtask

  task automatic check_tx(input string name, input int start, input int n, input logic [7:0] base);
    logic [7:0] eb;
    check({name, " tx count"}, h_tx_n - start, n);
    for (int i = 0; i < n; i++) begin
      eb = base + 8'(i);
      check($sformatf("%s tx[%0d]", name, i), int'(h_tx_log[start + i]), int'(eb));
    end
  endtask

  typedef struct {
    int         n_rx;
    logic [7:0] rx_base;
    int         n_tx;
    logic [7:0] tx_base;
    int         exp_rd_lo;
    int         exp_wr_lo;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rx, s_tx, s_rd, s_wr, s_host, s_nb, budget, rd_seen;

    vecs[0] = '{16, 8'h00, 0, 8'h00, 16, 0};
    vecs[1] = '{0,  8'h00, 8, 8'hA0, 0,  8};
    vecs[2] = '{8,  8'h30, 8, 8'hC0, 8,  8};
    vecs[3] = '{4,  8'h60, 0, 8'h00, 4,  0};

    reset = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset oe_n", oe_n, 1);
    check("reset rd_n", rd_n, 1);
    check("reset wr_n", wr_n, 1);
    check("reset siwu_n", siwu_n, 1);
    check("reset adbus_oe", adbus_oe, 0);
    check("reset adbus_o", adbus_o, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset tx_ready", tx_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      s_rx = c_rx_n; s_tx = h_tx_n; s_rd = rd_lo_cnt; s_wr = wr_lo_cnt;
      queue_rx(vecs[v].n_rx, vecs[v].rx_base);
      queue_tx(vecs[v].n_tx, vecs[v].tx_base);
      wait_done(s_rx + vecs[v].n_rx, s_tx + vecs[v].n_tx, $sformatf("vec%0d", v));
      check_rx($sformatf("vec%0d", v), s_rx, vecs[v].n_rx, vecs[v].rx_base);
      check_tx($sformatf("vec%0d", v), s_tx, vecs[v].n_tx, vecs[v].tx_base);
      check($sformatf("vec%0d rd_n low cycles", v), rd_lo_cnt - s_rd, vecs[v].exp_rd_lo);
      check($sformatf("vec%0d wr_n low cycles", v), wr_lo_cnt - s_wr, vecs[v].exp_wr_lo);
    end

    // consumer stalls after two bytes: skid fills to four and reads stop
    s_rx = c_rx_n; s_host = h_rx_rd;
    queue_rx(16, 8'h10);
    budget = 200;
    while (c_rx_n - s_rx < 2 && budget > 0) begin @(negedge clk); budget--; end
    check("stall reach 2 bytes", (budget > 0) ? 1 : 0, 1);
    rx_ready = 1'b0;
    repeat (10) @(negedge clk);
    rd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rd_n) rd_seen++;
    end
    check("stall rd_n low cycles", rd_seen, 0);
    check("stall host bytes read", h_rx_rd - s_host, 6);
    check("stall rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_done(s_rx + 16, 0, "stall");
    check_rx("stall", s_rx, 16, 8'h10);

    // host TX FIFO goes full after three bytes: A3 is held and resent
    s_tx = h_tx_n;
    queue_tx(8, 8'hA0);
    budget = 200;
    while (h_tx_n - s_tx < 3 && budget > 0) begin @(negedge clk); budget--; end
    check("txe reach 3 bytes", (budget > 0) ? 1 : 0, 1);
    txe_force = 1'b1;
    repeat (10) @(negedge clk);
    check("txe held count", h_tx_n - s_tx, 3);
    txe_force = 1'b0;
    wait_done(0, s_tx + 8, "txe");
    check_tx("txe", s_tx, 8, 8'hA0);

    // both directions pending: round-robin bursts of four
    s_rx = c_rx_n; s_tx = h_tx_n; s_nb = n_bursts;
    queue_rx(12, 8'h70);
    queue_tx(12, 8'hD0);
    wait_done(s_rx + 12, s_tx + 12, "rr");
    check_rx("rr", s_rx, 12, 8'h70);
    check_tx("rr", s_tx, 12, 8'hD0);
    check("rr burst count", n_bursts - s_nb, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr burst%0d dir", i), int'(burst_dir[s_nb + i]), i % 2);
      check($sformatf("rr burst%0d len", i), burst_len[s_nb + i], 4);
    end

    // reset in the middle of an RX burst
    queue_rx(8, 8'h80);
    budget = 100;
    while (rd_n && budget > 0) begin @(negedge clk); budget--; end
    check("mid-burst rd_n low seen", (budget > 0) ? 1 : 0, 1);
    reset = 1'b1;
    h_flush = 1'b1;
    @(posedge clk);
    #1;
    check("midreset oe_n", oe_n, 1);
    check("midreset rd_n", rd_n, 1);
    check("midreset wr_n", wr_n, 1);
    check("midreset adbus_oe", adbus_oe, 0);
    check("midreset rx_valid", rx_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    h_flush = 1'b0;
    @(negedge clk);
    s_rx = c_rx_n;
    queue_rx(4, 8'h90);
    wait_done(s_rx + 4, 0, "postreset");
    check_rx("postreset", s_rx, 4, 8'h90);

    check("bus contention events", bus_viol, 0);
    check("oe_n-to-rd_n gap errors", oe_rd_bad, 0);
    check("rx grants observed", (oe_rd_seen > 0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
